// File: rtl/dbg_pkg.sv
// Shared types for the JTAG debug bridge: TAP state encoding, IR codes,
// status-word field offsets and the IEEE 1149.1 next-state function.
package dbg_pkg;

  typedef enum logic [3:0] {
    RTI, SDS, CDR, SDR, E1D, PDR, E2D, UDR,
    SIS, CIR, SIR, E1I, PIR, E2I, UIR, TLR
  } tap_state_t;

  localparam logic [3:0] IR_BYPASS  = 4'hF;
  localparam logic [3:0] IR_IDCODE  = 4'hE;
  localparam logic [3:0] IR_INJECT  = 4'hD;
  localparam logic [3:0] IR_DUTRST  = 4'hC;
  localparam logic [3:0] IR_STATUS  = 4'hB;
  localparam logic [3:0] IR_STEP    = 4'h7;
  localparam logic [3:0] IR_RUN     = 4'h0;
  localparam logic [3:0] IR_CAPTURE = 4'b0101;

  // Flag/count offsets above the dbus_in field; ovf sits just above count.
  localparam int ST_PRIO  = 0;
  localparam int ST_CFLAG = 1;
  localparam int ST_JFLAG = 2;
  localparam int ST_TFLAG = 3;
  localparam int ST_CNT   = 4;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    case (s)
      TLR:     return tms ? TLR : RTI;
      RTI:     return tms ? SDS : RTI;
      SDS:     return tms ? SIS : CDR;
      CDR:     return tms ? E1D : SDR;
      SDR:     return tms ? E1D : SDR;
      E1D:     return tms ? UDR : PDR;
      PDR:     return tms ? E2D : PDR;
      E2D:     return tms ? UDR : SDR;
      UDR:     return tms ? SDS : RTI;
      SIS:     return tms ? TLR : CIR;
      CIR:     return tms ? E1I : SIR;
      SIR:     return tms ? E1I : SIR;
      E1I:     return tms ? UIR : PIR;
      PIR:     return tms ? E2I : PIR;
      E2I:     return tms ? UIR : SIR;
      UIR:     return tms ? SDS : RTI;
      default: return TLR;
    endcase
  endfunction

endpackage

// File: rtl/dbg_sync_fifo.sv
// Generic single-clock FIFO with synchronous clear. A push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module dbg_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             wr_en;
  logic             rd_en;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign count = count_reg;
  // Gate the head to zero when empty so the output has a defined reset value.
  assign dout  = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (clr) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(wr_en) - CW'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/jtag_dbg_bridge_v2.sv
// JTAG debug bridge: oversampled JTAG pins drive a TAP controller whose DR
// scans inject instructions, read IDCODE/status and control CPU run state.
module jtag_dbg_bridge_v2
  import dbg_pkg::*;
#(
  parameter int                 INSTR_W    = 16,
  parameter int                 DATA_W     = 8,
  parameter int                 FIFO_DEPTH = 4,
  parameter logic [INSTR_W-1:0] JTAG_ID    = 'h1234
) (
  input  logic               sys_clk,
  input  logic               sys_por,
  input  logic               jtck,
  input  logic               jtms,
  input  logic               jtdi,
  output logic               jtdo,
  output logic               reset_out,
  output logic               halt_out,
  output logic               step_pulse,
  output logic               inject_valid,
  output logic [INSTR_W-1:0] inject_instr,
  input  logic               inject_ready,
  input  logic [DATA_W-1:0]  dbus_in,
  input  logic               tflag,
  input  logic               jflag,
  input  logic               cflag,
  input  logic               prio
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  // Pin order in the synchroniser vectors: {tck, tms, tdi}.
  logic [2:0]         sync1_reg, sync2_reg;
  logic               tck_dly_reg;
  logic               tck_rise, tck_fall, tms_s, tdi_s;

  tap_state_t         state_reg;
  logic [3:0]         ir_reg, ir_sft_reg;
  logic [INSTR_W-1:0] dr_reg;
  logic               status_cap_reg, ovf_reg;
  logic [INSTR_W-1:0] status_word;
  logic               is_bypass, push, pop, tlr_entry, fifo_clr, fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;

  always_ff @(posedge sys_clk) begin
    if (sys_por) begin
      sync1_reg   <= '0;
      sync2_reg   <= '0;
      tck_dly_reg <= 1'b0;
    end else begin
      sync1_reg   <= {jtck, jtms, jtdi};
      sync2_reg   <= sync1_reg;
      tck_dly_reg <= sync2_reg[2];
    end
  end

  assign tck_rise = sync2_reg[2] & ~tck_dly_reg;
  assign tck_fall = ~sync2_reg[2] & tck_dly_reg;
  assign tms_s    = sync2_reg[1];
  assign tdi_s    = sync2_reg[0];

  assign is_bypass = !(ir_reg inside {IR_IDCODE, IR_INJECT, IR_DUTRST, IR_STATUS, IR_STEP, IR_RUN});

  always_comb begin
    status_word = '0;
    status_word[DATA_W-1:0]                = dbus_in;
    status_word[DATA_W+ST_PRIO]            = prio;
    status_word[DATA_W+ST_CFLAG]           = cflag;
    status_word[DATA_W+ST_JFLAG]           = jflag;
    status_word[DATA_W+ST_TFLAG]           = tflag;
    status_word[DATA_W+ST_CNT +: CNT_W]    = fifo_count;
    status_word[DATA_W+ST_CNT+CNT_W]       = ovf_reg;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_por) begin
      state_reg      <= TLR;
      ir_reg         <= IR_RUN;
      ir_sft_reg     <= '0;
      dr_reg         <= '0;
      jtdo           <= 1'b0;
      status_cap_reg <= 1'b0;
    end else begin
      status_cap_reg <= 1'b0;
      if (tck_rise) begin
        state_reg <= tap_next(state_reg, tms_s);
        case (state_reg)
          CIR: ir_sft_reg <= IR_CAPTURE;
          SIR: ir_sft_reg <= {ir_sft_reg[2:0], tdi_s};
          UIR: ir_reg     <= ir_sft_reg;
          CDR: begin
            if (ir_reg == IR_IDCODE)      dr_reg <= JTAG_ID;
            else if (ir_reg == IR_STATUS) dr_reg <= status_word;
            else                          dr_reg <= '0;
            status_cap_reg <= (ir_reg == IR_STATUS);
          end
          SDR: begin
            if (is_bypass) dr_reg[0] <= tdi_s;
            else           dr_reg    <= {dr_reg[INSTR_W-2:0], tdi_s};
          end
          default: ;
        endcase
      end
      if (state_reg == TLR) ir_reg <= IR_RUN;
      if (tck_fall) begin
        if (state_reg == SDR)      jtdo <= is_bypass ? dr_reg[0] : dr_reg[INSTR_W-1];
        else if (state_reg == SIR) jtdo <= ir_sft_reg[3];
      end
    end
  end

  assign push      = tck_rise && (state_reg == UDR) && (ir_reg == IR_INJECT);
  assign pop       = inject_valid & inject_ready;
  assign tlr_entry = tck_rise && (state_reg != TLR) && (tap_next(state_reg, tms_s) == TLR);
  assign fifo_clr  = sys_por || tlr_entry || (ir_reg == IR_DUTRST);
  assign inject_valid = !fifo_empty;

  dbg_sync_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .clr   (fifo_clr),
    .push  (push),
    .din   (dr_reg),
    .pop   (pop),
    .dout  (inject_instr),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_por) begin
      halt_out   <= 1'b0;
      reset_out  <= 1'b1;
      step_pulse <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      halt_out   <= (ir_reg == IR_INJECT) || (ir_reg == IR_STEP) || (ir_reg == IR_STATUS);
      reset_out  <= (ir_reg == IR_DUTRST);
      step_pulse <= tck_rise && (state_reg == UDR) && (ir_reg == IR_STEP);
      // A dropped push wins over the post-capture clear.
      if (push && fifo_full && !pop) ovf_reg <= 1'b1;
      else if (status_cap_reg)       ovf_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtag_dbg_bridge_v2.sv
// Randomised bench for jtag_dbg_bridge_v2: a bit-banged JTAG probe drives scans
// while a queue-based model of the inject FIFO scores every CPU-side pop.
module tb_jtag_dbg_bridge_v2;

  logic        sys_clk = 1'b0;
  logic        sys_por = 1'b1;
  logic        jtck = 1'b0, jtms = 1'b0, jtdi = 1'b0;
  logic        inject_ready = 1'b0;
  logic [7:0]  dbus_in = '0;
  logic        tflag = 1'b0, jflag = 1'b0, cflag = 1'b0, prio = 1'b0;
  logic        jtdo, reset_out, halt_out, step_pulse, inject_valid;
  logic [15:0] inject_instr;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q[$];
  bit          model_ovf = 1'b0;
  int          step_count = 0;
  bit          step_prev = 1'b0;

  jtag_dbg_bridge_v2 dut (
    .sys_clk(sys_clk), .sys_por(sys_por),
    .jtck(jtck), .jtms(jtms), .jtdi(jtdi), .jtdo(jtdo),
    .reset_out(reset_out), .halt_out(halt_out), .step_pulse(step_pulse),
    .inject_valid(inject_valid), .inject_instr(inject_instr), .inject_ready(inject_ready),
    .dbus_in(dbus_in), .tflag(tflag), .jflag(jflag), .cflag(cflag), .prio(prio)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: every CPU-side pop is compared with the model queue head.
  always begin
    @(negedge sys_clk);
    #1;
    if (inject_valid && inject_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL pop_unexpected: got %h expected no word", inject_instr);
      end else begin
        check("pop_data", {16'h0, inject_instr}, {16'h0, exp_q.pop_front()});
      end
    end
    if (step_pulse) begin
      step_count++;
      if (step_prev) begin
        checks++; errors++;
        $display("FAIL step_width: got pulse longer than 1 cycle expected 1");
      end
    end
    step_prev = step_pulse;
  end

  task automatic tck(input bit tms, input bit tdi, output bit tdo);
    tdo  = jtdo;
    jtms = tms;
    jtdi = tdi;
    jtck = 1'b1;
    repeat (5) @(negedge sys_clk);
    jtck = 1'b0;
    repeat (5) @(negedge sys_clk);
  endtask

  task automatic shift_ir(input logic [3:0] code, output logic [3:0] cap);
    bit b;
    tck(1, 0, b); tck(1, 0, b); tck(0, 0, b); tck(0, 0, b);
    for (int i = 3; i >= 0; i--) begin
      tck(i == 0, code[i], b);
      cap[i] = b;
    end
    tck(1, 0, b); tck(0, 0, b);
  endtask

  task automatic shift_dr(input logic [15:0] din, output logic [15:0] dout);
    bit b;
    tck(1, 0, b); tck(0, 0, b); tck(0, 0, b);
    for (int i = 15; i >= 0; i--) begin
      tck(i == 0, din[i], b);
      dout[i] = b;
    end
    tck(1, 0, b); tck(0, 0, b);
  endtask

  task automatic select_ir(input logic [3:0] code);
    logic [3:0] cap;
    shift_ir(code, cap);
    check("ir_capture", {28'h0, cap}, 32'h5);
  endtask

  task automatic push_word(input logic [15:0] w);
    logic [15:0] d;
    shift_dr(w, d);
    if (exp_q.size() < 4) exp_q.push_back(w);
    else model_ovf = 1'b1;
  endtask

  task automatic status_check(input string name, output logic [15:0] d);
    logic [15:0] e;
    {tflag, jflag, cflag, prio} = 4'($urandom);
    dbus_in = 8'($urandom);
    e = {model_ovf, 3'(exp_q.size()), tflag, jflag, cflag, prio, dbus_in};
    shift_dr(16'h0, d);
    check(name, {16'h0, d}, {16'h0, e});
    model_ovf = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    while (exp_q.size() > 0 && budget < 400) begin
      @(negedge sys_clk);
      inject_ready = 1'($urandom_range(0, 1));
      budget++;
    end
    @(negedge sys_clk);
    inject_ready = 1'b0;
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d words left expected 0", exp_q.size());
      exp_q.delete();
    end
    check("drain_empty", {31'h0, inject_valid}, 32'h0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] d, w;
    bit b;
    int n;

    repeat (3) @(negedge sys_clk);
    check("rst_jtdo", {31'h0, jtdo}, 32'h0);
    check("rst_reset_out", {31'h0, reset_out}, 32'h1);
    check("rst_halt", {31'h0, halt_out}, 32'h0);
    check("rst_step", {31'h0, step_pulse}, 32'h0);
    check("rst_valid", {31'h0, inject_valid}, 32'h0);
    check("rst_instr", {16'h0, inject_instr}, 32'h0);
    sys_por = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("run_reset_out", {31'h0, reset_out}, 32'h0);

    for (int i = 0; i < 5; i++) tck(1, 0, b);
    tck(0, 0, b);

    // IDCODE and BYPASS readback
    select_ir(4'hE);
    w = 16'($urandom);
    shift_dr(w, d);
    check("idcode", {16'h0, d}, 32'h1234);
    select_ir(4'hF);
    w = 16'($urandom);
    shift_dr(w, d);
    check("bypass", {16'h0, d}, {16'h0, 1'b0, w[15:1]});

    // Single inject and handshake
    select_ir(4'hD);
    check("halt_inject", {31'h0, halt_out}, 32'h1);
    push_word(16'hA5C3);
    check("inject_valid", {31'h0, inject_valid}, 32'h1);
    check("inject_instr", {16'h0, inject_instr}, 32'hA5C3);
    @(negedge sys_clk);
    inject_ready = 1'b1;
    @(negedge sys_clk);
    inject_ready = 1'b0;
    @(negedge sys_clk);
    check("valid_after_pop", {31'h0, inject_valid}, 32'h0);

    // Overflow
    for (int i = 1; i <= 5; i++) push_word(16'(i));
    select_ir(4'hB);
    status_check("status_ovf", d);
    check("status_ovf_cnt", {28'h0, d[15:12]}, 32'hC);
    drain();
    status_check("status_cleared", d);
    check("status_cleared_cnt", {28'h0, d[15:12]}, 32'h0);

    // Randomised rounds
    for (int r = 0; r < 4; r++) begin
      select_ir(4'hD);
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) push_word(16'($urandom));
      select_ir(4'hB);
      status_check("status_rand", d);
      drain();
    end

    // Single step
    select_ir(4'h7);
    check("halt_step", {31'h0, halt_out}, 32'h1);
    step_count = 0;
    for (int k = 0; k < 3; k++) shift_dr(16'($urandom), d);
    repeat (3) @(negedge sys_clk);
    check("step_count", step_count, 3);

    // DUT reset flushes the queue
    select_ir(4'hD);
    push_word(16'($urandom));
    push_word(16'($urandom));
    check("two_queued", {31'h0, inject_valid}, 32'h1);
    select_ir(4'hC);
    exp_q.delete();
    check("dutrst_reset_out", {31'h0, reset_out}, 32'h1);
    check("dutrst_valid", {31'h0, inject_valid}, 32'h0);
    select_ir(4'h0);
    check("run_reset_out2", {31'h0, reset_out}, 32'h0);
    check("run_halt", {31'h0, halt_out}, 32'h0);

    // Reset in the middle of an INJECT scan
    select_ir(4'hD);
    tck(1, 0, b); tck(0, 0, b); tck(0, 0, b);
    for (int k = 0; k < 8; k++) tck(0, 1'($urandom), b);
    sys_por = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("por_jtdo", {31'h0, jtdo}, 32'h0);
    check("por_reset_out", {31'h0, reset_out}, 32'h1);
    check("por_halt", {31'h0, halt_out}, 32'h0);
    check("por_valid", {31'h0, inject_valid}, 32'h0);
    sys_por = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("post_por_reset_out", {31'h0, reset_out}, 32'h0);
    check("post_por_halt", {31'h0, halt_out}, 32'h0);
    tck(0, 0, b);
    shift_dr(16'($urandom), d);
    repeat (3) @(negedge sys_clk);
    check("post_por_no_push", {31'h0, inject_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
